// File: rtl/hazard_pkg.sv
// Shared constants and types for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 8;

  // addi x0, x0, 0: what a flushed IF/ID or a bubbled ID/EX ends up holding
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Pipeline control priority, highest value wins
  typedef enum logic [1:0] {
    PRI_NONE   = 2'd0,
    PRI_STALL  = 2'd1,
    PRI_FLUSH  = 2'd2,
    PRI_FREEZE = 2'd3
  } hz_pri_e;

  function automatic int busy_width(input int mem_lat);
    return $clog2(mem_lat) + 1;
  endfunction

endpackage

// File: rtl/hazard_busy_cnt.sv
// One register's pending-load countdown: reload on launch, count down while
// memory is ready, hold while the pipe is frozen.
module hazard_busy_cnt #(
  parameter int W        = 1,
  parameter int LOAD_VAL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic hold,
  output logic busy
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // A fresh launch overrides whatever was still counting down
  always_comb begin
    cnt_next = cnt_reg;
    if (launch) begin
      cnt_next = W'(LOAD_VAL);
    end else if (!hold && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit for a data memory with MEM_LAT cycles of load latency,
// arbitrating freeze, branch flush and load-use stall for the front end.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_Rs1,
  input  logic [REG_ADDR_W-1:0] if_id_Rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic                  id_ex_MemRead,
  input  logic                  id_ex_RegWrite,
  input  logic [REG_ADDR_W-1:0] id_ex_Rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  hazard_detected,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int LAT      = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                            (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int BUSY_W   = busy_width(LAT);

  logic                launch;
  logic [NUM_REGS-1:0] busy_vec;
  logic                rs1_luh;
  logic                rs2_luh;
  logic                luh;
  hz_pri_e             pri;
  logic [CNT_W-1:0]    stall_cycles_reg;

  assign launch = id_ex_MemRead & id_ex_RegWrite & (id_ex_Rd != '0) & ~mem_busy;

  // x0 has no cell: it can never hold a pending load
  assign busy_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cell
      hazard_busy_cnt #(
        .W        (BUSY_W),
        .LOAD_VAL (LAT - 1)
      ) u_cell (
        .clk    (clk),
        .reset  (reset),
        .launch (launch && (id_ex_Rd == REG_ADDR_W'(gi))),
        .hold   (mem_busy),
        .busy   (busy_vec[gi])
      );
    end
  endgenerate

  // The load in EX itself (term A) covers the cycle before its cell is loaded
  always_comb begin
    rs1_luh = if_id_use_rs1 && (if_id_Rs1 != '0) &&
              ((launch && (id_ex_Rd == if_id_Rs1)) || busy_vec[if_id_Rs1]);
    rs2_luh = if_id_use_rs2 && (if_id_Rs2 != '0) &&
              ((launch && (id_ex_Rd == if_id_Rs2)) || busy_vec[if_id_Rs2]);
    luh     = rs1_luh | rs2_luh;
  end

  always_comb begin
    pri = PRI_NONE;
    if (mem_busy) begin
      pri = PRI_FREEZE;
    end else if (ex_branch_taken) begin
      pri = PRI_FLUSH;
    end else if (luh) begin
      pri = PRI_STALL;
    end
  end

  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    hazard_detected = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (pri)
        PRI_FREEZE: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        PRI_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        PRI_STALL: begin
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
          id_ex_bubble    = 1'b1;
          hazard_detected = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if ((pri == PRI_STALL) && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives two scoreboards (MEM_LAT=1 / 32-bit counter, MEM_LAT=3 / 4-bit counter)
// with directed then random stimulus against a ready-time reference model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_Rs1, if_id_Rs2, id_ex_Rd;
  logic       if_id_use_rs1, if_id_use_rs2;
  logic       id_ex_MemRead, id_ex_RegWrite;
  logic       ex_branch_taken, mem_busy;

  logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, hazard_a;
  logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, hazard_b;
  logic [31:0] stall_cycles_a;
  logic [3:0]  stall_cycles_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a register is forwardable once the count of unfrozen
  // cycles reaches the value recorded at launch plus the latency.
  int     act;
  int     ready [2][32];
  longint cnt   [2];
  int     lat   [2] = '{1, 3};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(5), .MEM_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_RegWrite(id_ex_RegWrite), .id_ex_Rd(id_ex_Rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
    .id_ex_bubble(id_ex_bubble_a), .hazard_detected(hazard_a), .stall_cycles(stall_cycles_a)
  );

  hazard_scoreboard #(.REG_ADDR_W(5), .MEM_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_RegWrite(id_ex_RegWrite), .id_ex_Rd(id_ex_Rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
    .id_ex_bubble(id_ex_bubble_b), .hazard_detected(hazard_b), .stall_cycles(stall_cycles_b)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic launch_now();
    return id_ex_MemRead && id_ex_RegWrite && (id_ex_Rd != 5'd0) && !mem_busy;
  endfunction

  function automatic logic src_haz(input int k, input logic use_bit, input logic [4:0] s);
    if (!use_bit || s == 5'd0) return 1'b0;
    if (launch_now() && id_ex_Rd == s) return 1'b1;
    return act < ready[k][s];
  endfunction

  function automatic logic luh_m(input int k);
    return src_haz(k, if_id_use_rs1, if_id_Rs1) || src_haz(k, if_id_use_rs2, if_id_Rs2);
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, hazard_detected}
  function automatic logic [4:0] exp_ctl(input int k);
    if (reset)           return 5'b00110;
    if (mem_busy)        return 5'b00000;
    if (ex_branch_taken) return 5'b11110;
    if (luh_m(k))        return 5'b00011;
    return 5'b11000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic set_in(input logic rst, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic ld,
                        input logic rw, input logic [4:0] rd, input logic br, input logic mb);
    reset = rst; if_id_Rs1 = r1; if_id_use_rs1 = u1; if_id_Rs2 = r2; if_id_use_rs2 = u2;
    id_ex_MemRead = ld; id_ex_RegWrite = rw; id_ex_Rd = rd;
    ex_branch_taken = br; mem_busy = mb;
  endtask

  // Check outputs mid-cycle, then advance the model across the clock edge
  task automatic tick();
    logic luh_v [2];
    @(negedge clk);
    chk("ctl_a", {27'd0, pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, hazard_a},
        {27'd0, exp_ctl(0)});
    chk("ctl_b", {27'd0, pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, hazard_b},
        {27'd0, exp_ctl(1)});
    chk("cnt_a", stall_cycles_a, cnt[0][31:0]);
    chk("cnt_b", {28'd0, stall_cycles_b}, cnt[1][31:0]);
    $display("cyc=%0d rst=%b rs1=%0d/%b rs2=%0d/%b ld=%b rd=%0d br=%b mb=%b | a:haz=%b cnt=%0d b:haz=%b cnt=%0d",
             cyc, reset, if_id_Rs1, if_id_use_rs1, if_id_Rs2, if_id_use_rs2, id_ex_MemRead,
             id_ex_Rd, ex_branch_taken, mem_busy, hazard_a, stall_cycles_a, hazard_b, stall_cycles_b);
    for (int k = 0; k < 2; k++) luh_v[k] = luh_m(k);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0;
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
      end
    end else if (!mem_busy) begin
      for (int k = 0; k < 2; k++) begin
        if (!ex_branch_taken && luh_v[k] && cnt[k] < cmax[k]) cnt[k]++;
        if (launch_now()) ready[k][id_ex_Rd] = act + lat[k];
      end
      act++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    act = 0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      for (int r = 0; r < 32; r++) ready[k][r] = 0;
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick(); tick();

    // lw x5 then dependent add directly behind it
    set_in(0, 5, 1, 0, 0, 1, 1, 5, 0, 0); tick();
    set_in(0, 5, 1, 0, 0, 0, 0, 0, 0, 0); repeat (4) tick();

    // lw x7, unrelated instruction, then dependent add at distance 2
    set_in(0, 1, 1, 2, 1, 1, 1, 7, 0, 0); tick();
    set_in(0, 3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 7, 1, 7, 1, 0, 0, 0, 0, 0); repeat (3) tick();

    // load to x0, and a dependent with its use bit cleared
    set_in(0, 0, 1, 0, 1, 1, 1, 0, 0, 0); tick();
    set_in(0, 8, 0, 8, 0, 1, 1, 8, 0, 0); tick();
    set_in(0, 8, 1, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();

    // load-use coinciding with a taken branch
    set_in(0, 10, 1, 0, 0, 1, 1, 10, 1, 0); tick();
    set_in(0, 10, 1, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 10, 1, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();

    // freeze for 4 cycles while x9 is pending
    set_in(0, 9, 1, 0, 0, 1, 1, 9, 0, 0); tick();
    set_in(0, 9, 1, 0, 0, 0, 0, 0, 0, 1); repeat (4) tick();
    set_in(0, 9, 1, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();

    // reset mid-stall while x4 is pending
    set_in(0, 4, 1, 0, 0, 1, 1, 4, 0, 0); tick();
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 4, 1, 4, 1, 0, 0, 0, 0, 0); repeat (2) tick();

    // continuous stall for 20 cycles: saturates the 4-bit counter
    set_in(0, 6, 1, 6, 1, 1, 1, 6, 0, 0); repeat (20) tick();
    set_in(0, 6, 1, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();

    // random traffic on a small register window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 99) < 2),
             5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), 1'($urandom),
             ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 80),
             5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
